mem_bus_initiator: RTL and testbench

- Initiator (master) side of the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_instr/mem_rdata).
- Drives the memory model from a fuzzing stimulus source, so memory can be exercised standalone without the core.
- Accepts one byte, halfword or word load/store command at a time, performs the bus handshake, and returns the response.
- Lane-extracts and sign/zero-extends read data; flags misalignment and timeout.

---
 rtl/mem_bus_initiator.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_bus_initiator.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: initiator side of the PicoRV32 native memory interface.
// Takes one byte/half/word load or store command at a time, runs the
// mem_valid/mem_ready handshake, and returns a lane-extracted, sign/zero-extended
// response. Misaligned commands are answered without a bus cycle; a bus cycle
// that sees no mem_ready for TIMEOUT_CYCLES cycles is aborted.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   cmd_*_i / cmd_ready_o    command channel (valid/ready)
//   rsp_*_o / rsp_ready_i    response channel (valid/ready); rsp_err_o 0=OK 1=MISALIGNED 2=TIMEOUT
//   mem_*_o / mem_*_i        PicoRV32 native memory bus
//   txn_count_o              completed bus transactions (OK or TIMEOUT), wrapping
module mem_bus_initiator #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic                cmd_instr_i,
  input  logic [1:0]          cmd_size_i,
  input  logic                cmd_signed_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_err_o,
  output logic                mem_valid_o,
  output logic                mem_instr_o,
  input  logic                mem_ready_i,
  output logic [31:0]         mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [31:0]         txn_count_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [1:0]  ErrOk         = 2'd0;
  localparam logic [1:0]  ErrMisaligned = 2'd1;
  localparam logic [1:0]  ErrTimeout    = 2'd2;
  localparam logic [15:0] TmoLast       = 16'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic               mem_valid_q, mem_valid_d;
  logic               mem_instr_q, mem_instr_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic [31:0]        txn_count_q, txn_count_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  // Command attributes kept for shaping the load result.
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic               write_q, write_d;
  logic [1:0]         off_q, off_d;

  logic               misaligned;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  st_wdata;
  logic [3:0]         st_wstrb;

  always_comb begin
    unique case (cmd_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = cmd_addr_i[0];
      2'd2:    misaligned = |cmd_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes; strobes select the addressed lanes.
  always_comb begin
    unique case (cmd_size_i)
      2'd0: begin
        st_wdata = {4{cmd_wdata_i[7:0]}};
        st_wstrb = 4'b0001 << cmd_addr_i[1:0];
      end
      2'd1: begin
        st_wdata = {2{cmd_wdata_i[15:0]}};
        st_wstrb = 4'b0011 << cmd_addr_i[1:0];
      end
      default: begin
        st_wdata = cmd_wdata_i;
        st_wstrb = 4'hF;
      end
    endcase
    if (!cmd_write_i) begin
      st_wstrb = 4'h0;
    end
  end

  always_comb begin
    byte_lane = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_lane = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (size_q)
      2'd0:    load_data = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      2'd1:    load_data = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      default: load_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    txn_count_d = txn_count_q;
    tmo_cnt_d   = tmo_cnt_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    off_d       = off_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          if (misaligned) begin
            state_d     = StResp;
            rsp_rdata_d = '0;
            rsp_err_d   = ErrMisaligned;
          end else begin
            state_d     = StReq;
            mem_addr_d  = {cmd_addr_i[31:2], 2'b00};
            mem_instr_d = cmd_instr_i & ~cmd_write_i;
            mem_wdata_d = st_wdata;
            mem_wstrb_d = st_wstrb;
            tmo_cnt_d   = '0;
            size_d      = cmd_size_i;
            signed_d    = cmd_signed_i;
            write_d     = cmd_write_i;
            off_d       = cmd_addr_i[1:0];
          end
        end
      end
      StReq: begin
        // Ready takes priority over an expiring timeout in the same cycle.
        if (mem_ready_i) begin
          state_d     = StResp;
          rsp_rdata_d = write_q ? '0 : load_data;
          rsp_err_d   = ErrOk;
          mem_wstrb_d = 4'h0;
          txn_count_d = txn_count_q + 32'd1;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d     = StResp;
          rsp_rdata_d = '0;
          rsp_err_d   = ErrTimeout;
          mem_wstrb_d = 4'h0;
          txn_count_d = txn_count_q + 32'd1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d   = StIdle;
          tmo_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake flags are registered copies of the next state.
    cmd_ready_d = (state_d == StIdle);
    mem_valid_d = (state_d == StReq);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ErrOk;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      txn_count_q <= '0;
      tmo_cnt_q   <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      txn_count_q <= txn_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      off_q       <= off_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_instr_o = mem_instr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign txn_count_o = txn_count_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Testbench for mem_bus_initiator: scoreboard of expected bus requests and
// responses, filled by the command driver from a behavioural model; a memory
// responder and a response monitor pop and compare independently.
module tb_mem_bus_initiator;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_instr, cmd_signed;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] txn_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_initiator #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_instr_i  (cmd_instr),
    .cmd_size_i   (cmd_size),
    .cmd_signed_i (cmd_signed),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_valid_o  (mem_valid),
    .mem_instr_o  (mem_instr),
    .mem_ready_i  (mem_ready),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wstrb_o  (mem_wstrb),
    .mem_rdata_i  (mem_rdata),
    .txn_count_o  (txn_count)
  );

  // k = bus cycle (1-based) in which the memory raises mem_ready; 0 = never.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic        wr;
    logic [31:0] rdata;
    int          k;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [31:0] txn;
  } rsp_t;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] exp_txn   = '0;
  int          rsp_stall = 0;
  bit          rsp_fast  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected bus request and response from the command alone.
  function automatic void model(input logic w, input logic ins, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input int k,
                                output bit mis, output bus_t b, output rsp_t r);
    longint nbytes, off, v, bits;
    nbytes = longint'(1) << sz;
    off    = longint'(a % 4);
    mis    = (sz == 2'd3) || ((a % nbytes) != 0);
    b.addr  = a - 32'(off);
    b.instr = ins && !w;
    b.wr    = w;
    b.k     = k;
    b.rdata = rd;
    b.wstrb = w ? 4'(((longint'(1) << nbytes) - 1) << off) : 4'h0;
    if (nbytes == 1)      b.wdata = (d & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) b.wdata = (d & 32'hFFFF) * 32'h0001_0001;
    else                  b.wdata = d;
    r.txn = '0;
    if (mis) begin
      r.rdata = '0;
      r.err   = 2'd1;
    end else if (k < 1 || k > TMO) begin
      r.rdata = '0;
      r.err   = 2'd2;
    end else if (w) begin
      r.rdata = '0;
      r.err   = 2'd0;
    end else begin
      r.err = 2'd0;
      v     = longint'(rd) >> (off * 8);
      if (nbytes < 4) begin
        bits = nbytes * 8;
        v    = v % (longint'(1) << bits);
        if (sg && v >= (longint'(1) << (bits - 1))) v = v + 64'h1_0000_0000 - (longint'(1) << bits);
      end
      r.rdata = 32'(v);
    end
  endfunction

  task automatic issue(input logic w, input logic ins, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                       input int k, input bit want_rsp = 1'b1);
    bit   mis;
    bus_t b;
    rsp_t r;
    int   n;
    model(w, ins, sz, sg, a, d, rd, k, mis, b, r);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_instr  = ins;
    cmd_size   = sz;
    cmd_signed = sg;
    cmd_addr   = a;
    cmd_wdata  = d;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready stayed 0, expected 1 within 500 cycles");
      cmd_valid = 1'b0;
      return;
    end
    if (!mis) begin
      exp_txn++;
      bus_q.push_back(b);
    end
    r.txn = exp_txn;
    if (want_rsp) rsp_q.push_back(r);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    chk("drain_bus_q", 32'(bus_q.size()), 32'd0);
  endtask

  // Memory responder: checks each bus request and its stability, answers after k cycles.
  initial begin : responder
    bus_t b;
    int   cyc;
    int   exp_len;
    bit   act;
    act       = 1'b0;
    cyc       = 0;
    b         = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        act       = 1'b0;
        mem_ready = 1'b0;
        continue;
      end
      if (act && !mem_valid) begin
        exp_len = (b.k >= 1 && b.k <= TMO) ? b.k : TMO;
        chk("mem_valid_cycles", 32'(cyc), 32'(exp_len));
        act = 1'b0;
      end
      if (mem_valid) begin
        if (!act) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_valid_unexpected: got 1, expected 0 (t=%0t)", $time);
          end else begin
            b   = bus_q.pop_front();
            act = 1'b1;
            cyc = 0;
          end
        end
        if (act) begin
          cyc++;
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(b.wstrb));
          chk("mem_instr", 32'(mem_instr), 32'(b.instr));
          if (b.wr) chk("mem_wdata", mem_wdata, b.wdata);
          mem_ready = (cyc == b.k);
          mem_rdata = (cyc == b.k) ? b.rdata : $urandom;
        end else begin
          mem_ready = 1'b0;
        end
      end else begin
        // Ready outside a request must be ignored.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: pops the scoreboard at each response handshake.
  initial begin : rsp_mon
    rsp_t        e;
    bit          hold;
    logic [31:0] h_d;
    logic [1:0]  h_e;
    hold      = 1'b0;
    h_d       = '0;
    h_e       = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold      = 1'b0;
        rsp_ready = 1'b0;
        continue;
      end
      if (hold) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_hold_rdata", rsp_rdata, h_d);
        chk("rsp_hold_err", 32'(rsp_err), 32'(h_e));
      end
      if (rsp_valid && rsp_stall > 0) begin
        rsp_ready = 1'b0;
        rsp_stall--;
      end else begin
        rsp_ready = rsp_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid) chk("cmd_ready_during_rsp", 32'(cmd_ready), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid 1, expected 0 (t=%0t)", $time);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("txn_count", txn_count, e.txn);
        end
        hold = 1'b0;
      end else begin
        hold = rsp_valid;
        h_d  = rsp_rdata;
        h_e  = rsp_err;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] a;
    logic [1:0]  sz;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_instr  = 1'b0;
    cmd_size   = 2'd0;
    cmd_signed = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_txn_count", txn_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Word load with ready tied high, plus handshake latency.
    rsp_fast = 1'b1;
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, 32'hDEAD_BEEF, 1);
    chk("lat_mem_valid_after_accept", 32'(mem_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lat_mem_valid_dropped", 32'(mem_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("lat_rsp_valid_dropped", 32'(rsp_valid), 32'd0);

    // Byte/half loads with sign and zero extension.
    issue(1'b0, 1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0, 32'h8012_3456, 1);
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0, 32'h8012_3456, 2);
    issue(1'b0, 1'b0, 2'd1, 1'b1, 32'h0001_0002, 32'h0, 32'h8012_3456, 3);
    // Stores: lane replication and strobes.
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h0002_0001, 32'h0000_00A5, 32'h0, 1);
    issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h0002_0002, 32'h0000_1234, 32'h0, 2);
    // Instruction fetch qualifier.
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 1);
    // Misaligned commands: no bus cycle.
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0001_0002, 32'h0, 32'h0, 1);
    issue(1'b0, 1'b0, 2'd1, 1'b0, 32'h0001_0001, 32'h0, 32'h0, 1);
    issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 1);
    // Timeout, and ready arriving in the last permitted cycle.
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0004_0000, 32'h0, 32'h1111_2222, 0);
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0004_0004, 32'h0, 32'h3333_4444, TMO);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0004_0008, 32'hCAFE_F00D, 32'h0, TMO + 1);
    drain();

    // Back-pressured response.
    rsp_stall = 5;
    issue(1'b0, 1'b0, 2'd1, 1'b0, 32'h0005_0002, 32'h0, 32'hABCD_0123, 2);
    drain();
    rsp_fast = 1'b0;

    for (int i = 0; i < 300; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), a, $urandom, $urandom, int'($urandom_range(0, 10)));
    end
    drain();

    // Reset in the middle of a request abandons it without a response.
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0006_0000, 32'h0, 32'h0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midreq_mem_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("midreq_reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("midreq_reset_txn_count", txn_count, 32'd0);
    chk("midreq_reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midreq_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_txn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_reset_bus_q", 32'(bus_q.size()), 32'd0);

    // Fresh transaction after reset counts from zero.
    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h0007_0002, 32'h0, 32'h00C3_0000, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
